index_aux_lut_loader: RTL and testbench
=======================================

INDEX_AUX_LUT_LOADER -- requirements
Module: index_aux_lut_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 512: number of LUT addresses loaded per run.
REQ-002 SHALL have parameter ADDR_W, default 9: LUT address width.
REQ-003 SHALL have parameter DATA_W, default 8: LUT bank data width.
REQ-004 SHALL have port clk  input  1: single clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, synchronous, active-low.
REQ-006 SHALL have port start  input  1: one-cycle request to begin a load run.
REQ-007 SHALL have port abort  input  1: terminate the current run.
REQ-008 SHALL have port rd_active  input  1: the LUT read side is enabled; writes must stall.
REQ-009 SHALL have port in_valid  input  1: a source byte is present.
REQ-010 SHALL have port in_data  input  DATA_W: source byte.
REQ-011 SHALL have port in_ready  output  1: the loader accepts in_data this cycle.
REQ-012 SHALL have port wr_en  output  1: write strobe, common to all four banks.
REQ-013 SHALL have port wr_addr  output  ADDR_W: write address, common to all four banks.
REQ-014 SHALL have ports wr_data1, wr_data2, wr_data3, wr_data4  output  DATA_W each: data for banks 1-4.
REQ-015 SHALL have port busy  output  1: a run is in progress.
REQ-016 SHALL have port done  output  1: one-cycle pulse when a run completes.

Function
REQ-017 SHALL implement the states IDLE, COLLECT, WRITE and FINISH.
REQ-018 IDLE SHALL move to COLLECT on start=1, clearing the byte counter (0-3) and the address counter.
REQ-019 In COLLECT, in_ready SHALL be 1 whenever rd_active=0; in all other states, or when rd_active=1, in_ready SHALL be 0.
REQ-020 A byte SHALL be accepted only on a cycle with in_valid=1 and in_ready=1.
REQ-021 Accepted byte k of a group SHALL be latched into wr_data(k+1), for k = 0..3 in arrival order.
REQ-022 Acceptance of byte 3 SHALL move the FSM to WRITE.
REQ-023 In WRITE, when rd_active=0, wr_en SHALL be 1 for exactly one cycle, with wr_addr equal to the address counter; this is the cycle after byte 3 is accepted.
REQ-024 In WRITE, when rd_active=1, wr_en SHALL stay 0 and the FSM SHALL hold WRITE with data and address stable.
REQ-025 After the write, when the address is below DEPTH-1, the address SHALL increment and the FSM SHALL return to COLLECT.
REQ-026 After the write, when the address equals DEPTH-1, the FSM SHALL go to FINISH and the address counter SHALL wrap to 0.
REQ-027 FINISH SHALL assert done for one cycle and return to IDLE.
REQ-028 busy SHALL be 1 in COLLECT, WRITE and FINISH, and 0 in IDLE.
REQ-029 A start received while busy=1 SHALL be ignored.
REQ-030 abort=1 in any state SHALL return the FSM to IDLE next cycle with no wr_en and no done; a partial group SHALL be discarded.
REQ-031 When abort and start are both 1 in the same cycle, abort SHALL take priority.
REQ-032 wr_en SHALL never be 1 in a cycle where rd_active=1.
REQ-033 A byte arriving with in_valid=1 while in_ready=0 SHALL NOT be consumed and SHALL be held by the source.

Reset
REQ-034 On rst_n=0 sampled at clk, the FSM SHALL go to IDLE and clear both counters.
REQ-035 Reset SHALL set in_ready, wr_en, busy and done to 0, and wr_addr and wr_data1-4 to 0.
REQ-036 Reset asserted mid-run SHALL discard the run without any further write.

Structure
REQ-037 Package index_aux_pkg SHALL hold DEPTH, ADDR_W, DATA_W defaults and the FSM state type.
REQ-038 Byte-lane latching and the byte counter SHALL sit in one sub-module, index_aux_byte_packer; the FSM and address counter SHALL stay in the top level.

Verification
REQ-039 start, then bytes 0x01,0x02,0x03,0x04 with in_valid held -> one cycle later wr_en=1, wr_addr=0, wr_data1..4=01,02,03,04.
REQ-040 Full run of 2048 bytes -> 512 writes at addresses 0..511 in order, then done pulses once and busy=0 next cycle.
REQ-041 rd_active=1 asserted for 5 cycles during WRITE -> no wr_en for those 5 cycles; write occurs in the first cycle with rd_active=0, values unchanged.
REQ-042 abort after 2 bytes of group 3 -> IDLE next cycle, no write to address 3, no done; a new start then writes address 0 first.
REQ-043 rst_n=0 mid-run at address 100 -> all outputs 0 next cycle; no further wr_en until a new start.
REQ-044 start pulsed during COLLECT, and abort with start in the same cycle -> the first start is ignored; the second pair yields IDLE with busy=0.

Source files
------------

// File: rtl/index_aux_pkg.sv
// rtl/index_aux_pkg.sv - shared defaults and FSM state type for the index aux LUT loader
package index_aux_pkg;

    localparam int DEPTH_DEF  = 512;
    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_FINISH  = 2'd3
    } state_t;

endpackage

// File: rtl/index_aux_byte_packer.sv
// rtl/index_aux_byte_packer.sv - gathers four accepted bytes into the four bank data lanes
module index_aux_byte_packer
    import index_aux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              accept,
    input  logic [DATA_W-1:0] in_data,
    output logic              last,
    output logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] data2,
    output logic [DATA_W-1:0] data3,
    output logic [DATA_W-1:0] data4
);

    logic [1:0] byte_cnt;

    // clear wins over accept so an aborted partial group never completes
    assign last = accept && !clear && (byte_cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_cnt <= 2'd0;
            data1    <= '0;
            data2    <= '0;
            data3    <= '0;
            data4    <= '0;
        end else if (clear) begin
            byte_cnt <= 2'd0;
        end else if (accept) begin
            case (byte_cnt)
                2'd0:    data1 <= in_data;
                2'd1:    data2 <= in_data;
                2'd2:    data3 <= in_data;
                default: data4 <= in_data;
            endcase
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/index_aux_lut_loader.sv
// rtl/index_aux_lut_loader.sv - streams bytes into four LUT banks, one address per four bytes
module index_aux_lut_loader
    import index_aux_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              rd_active,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data1,
    output logic [DATA_W-1:0] wr_data2,
    output logic [DATA_W-1:0] wr_data3,
    output logic [DATA_W-1:0] wr_data4,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic              start_run;
    logic              addr_inc;
    logic              addr_wrap;
    logic              group_last;
    logic              accept;

    assign in_ready = (state == ST_COLLECT) && !rd_active;
    assign accept   = in_valid && in_ready;
    assign busy     = (state != ST_IDLE);
    assign wr_addr  = addr;

    index_aux_byte_packer #(
        .DATA_W (DATA_W)
    ) u_packer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (abort || start_run),
        .accept  (accept),
        .in_data (in_data),
        .last    (group_last),
        .data1   (wr_data1),
        .data2   (wr_data2),
        .data3   (wr_data3),
        .data4   (wr_data4)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            addr  <= '0;
        end else begin
            state <= state_nxt;
            if (start_run || addr_wrap) begin
                addr <= '0;
            end else if (addr_inc) begin
                addr <= addr + ADDR_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        start_run = 1'b0;
        addr_inc  = 1'b0;
        addr_wrap = 1'b0;
        wr_en     = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_nxt = ST_COLLECT;
                    start_run = 1'b1;
                end
            end
            ST_COLLECT: begin
                if (group_last) begin
                    state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // the read side owns the banks while rd_active is high
                if (!rd_active) begin
                    wr_en = 1'b1;
                    if (addr == LAST_ADDR) begin
                        addr_wrap = 1'b1;
                        state_nxt = ST_FINISH;
                    end else begin
                        addr_inc  = 1'b1;
                        state_nxt = ST_COLLECT;
                    end
                end
            end
            ST_FINISH: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (abort) begin
            state_nxt = ST_IDLE;
            wr_en     = 1'b0;
            done      = 1'b0;
            addr_inc  = 1'b0;
            addr_wrap = 1'b0;
        end
    end

endmodule

// File: tb/tb_index_aux_lut_loader.sv
// tb/tb_index_aux_lut_loader.sv - directed vector bench for index_aux_lut_loader
module tb_index_aux_lut_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       rd_active;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       wr_en;
    logic [8:0] wr_addr;
    logic [7:0] wr_data1, wr_data2, wr_data3, wr_data4;
    logic       busy;
    logic       done;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    index_aux_lut_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .rd_active (rd_active),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data1  (wr_data1),
        .wr_data2  (wr_data2),
        .wr_data3  (wr_data3),
        .wr_data4  (wr_data4),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        logic        start;
        logic        abort;
        logic        rd;
        logic        vld;
        logic [7:0]  data;
        logic        exp_rdy;
        logic        exp_wen;
        logic [8:0]  exp_addr;
        logic        exp_busy;
        logic        exp_done;
        logic        chk_data;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(logic s, logic a, logic r, logic v, logic [7:0] d,
                                logic erdy, logic ewen, logic [8:0] eaddr, logic ebusy,
                                logic edone, logic cd, logic [31:0] edata);
        vec_t x;
        x.start = s; x.abort = a; x.rd = r; x.vld = v; x.data = d;
        x.exp_rdy = erdy; x.exp_wen = ewen; x.exp_addr = eaddr; x.exp_busy = ebusy;
        x.exp_done = edone; x.chk_data = cd; x.exp_data = edata;
        return x;
    endfunction

    function automatic logic [7:0] fbyte(int b);
        return 8'((b * 7 + 3) & 255);
    endfunction

    function automatic logic [31:0] cur_data();
        return {wr_data1, wr_data2, wr_data3, wr_data4};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0; abort = 1'b0; rd_active = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        next_cycle();
        start = 1'b0;
    endtask

    // four consecutive accepted bytes; returns with the write cycle about to be observed
    task automatic feed4(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        logic [7:0] bytes [4];
        bytes[0] = a; bytes[1] = b; bytes[2] = c; bytes[3] = d;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = bytes[k];
            next_cycle();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int b, writes, dones, cyc, wen_seen;
        logic done_seen;

        vecs[0]  = mk(0,0,0,0,8'h00, 0,0,9'd0,0,0, 0,32'h0);
        vecs[1]  = mk(1,0,0,0,8'h00, 0,0,9'd0,0,0, 0,32'h0);
        vecs[2]  = mk(0,0,0,1,8'h01, 1,0,9'd0,1,0, 0,32'h0);
        vecs[3]  = mk(0,0,0,1,8'h02, 1,0,9'd0,1,0, 0,32'h0);
        vecs[4]  = mk(0,0,0,1,8'h03, 1,0,9'd0,1,0, 0,32'h0);
        vecs[5]  = mk(0,0,0,1,8'h04, 1,0,9'd0,1,0, 0,32'h0);
        vecs[6]  = mk(0,0,0,0,8'h00, 0,1,9'd0,1,0, 1,32'h01020304);
        vecs[7]  = mk(0,0,1,0,8'h00, 0,0,9'd0,1,0, 0,32'h0);
        vecs[8]  = mk(0,0,1,1,8'hAA, 0,0,9'd0,1,0, 0,32'h0);
        vecs[9]  = mk(0,0,0,1,8'hAA, 1,0,9'd0,1,0, 0,32'h0);
        vecs[10] = mk(1,0,0,1,8'hBB, 1,0,9'd0,1,0, 0,32'h0);
        vecs[11] = mk(0,0,0,1,8'hCC, 1,0,9'd0,1,0, 0,32'h0);
        vecs[12] = mk(0,0,0,1,8'hDD, 1,0,9'd0,1,0, 0,32'h0);
        vecs[13] = mk(0,0,1,0,8'h00, 0,0,9'd0,1,0, 1,32'hAABBCCDD);
        vecs[14] = mk(0,0,0,0,8'h00, 0,1,9'd1,1,0, 1,32'hAABBCCDD);
        vecs[15] = mk(1,1,0,0,8'h55, 1,0,9'd0,1,0, 0,32'h0);
        vecs[16] = mk(0,0,0,0,8'h00, 0,0,9'd0,0,0, 0,32'h0);
        vecs[17] = mk(1,1,0,0,8'h00, 0,0,9'd0,0,0, 0,32'h0);
        vecs[18] = mk(0,0,0,0,8'h00, 0,0,9'd0,0,0, 0,32'h0);

        // reset state
        idle_inputs();
        rst_n = 1'b0;
        next_cycle();
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", cur_data(), 0);
        next_cycle();
        rst_n = 1'b1;

        // table: inputs applied for one cycle, outputs sampled mid-cycle
        for (int i = 0; i < 19; i++) begin
            start = vecs[i].start; abort = vecs[i].abort; rd_active = vecs[i].rd;
            in_valid = vecs[i].vld; in_data = vecs[i].data;
            @(negedge clk);
            chk($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].exp_rdy);
            chk($sformatf("vec%0d_wr_en", i), wr_en, vecs[i].exp_wen);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
            chk($sformatf("vec%0d_done", i), done, vecs[i].exp_done);
            if (vecs[i].exp_wen)
                chk($sformatf("vec%0d_wr_addr", i), wr_addr, vecs[i].exp_addr);
            if (vecs[i].chk_data)
                chk($sformatf("vec%0d_wr_data", i), cur_data(), vecs[i].exp_data);
            next_cycle();
        end
        idle_inputs();

        // full run with random read-side stalls
        do_reset();
        pulse_start();
        b = 0; writes = 0; dones = 0; cyc = 0; done_seen = 1'b0;
        while (!done_seen && cyc < 20000) begin
            rd_active = ($urandom_range(0, 3) == 0);
            in_valid  = (b < 2048);
            in_data   = fbyte(b);
            @(negedge clk);
            if (wr_en) begin
                chk("full_wr_addr", wr_addr, 32'(writes));
                chk("full_wr_data", cur_data(),
                    {fbyte(4*writes), fbyte(4*writes+1), fbyte(4*writes+2), fbyte(4*writes+3)});
                writes++;
            end
            if (rd_active)
                chk("full_no_wr_during_rd", wr_en, 0);
            if (in_valid && in_ready)
                b++;
            if (done) begin
                dones++;
                done_seen = 1'b1;
            end
            next_cycle();
            cyc++;
        end
        idle_inputs();
        @(negedge clk);
        chk("full_done_seen", done_seen, 1);
        chk("full_busy_after", busy, 0);
        chk("full_done_after", done, 0);
        chk("full_writes", writes, 512);
        chk("full_bytes", b, 2048);
        chk("full_done_count", dones, 1);
        next_cycle();

        // five-cycle read-side stall during WRITE
        do_reset();
        pulse_start();
        feed4(8'h10, 8'h20, 8'h30, 8'h40);
        rd_active = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_wr_en", wr_en, 0);
            chk("stall_data", cur_data(), 32'h10203040);
            next_cycle();
        end
        rd_active = 1'b0;
        @(negedge clk);
        chk("stall_release_wr_en", wr_en, 1);
        chk("stall_release_addr", wr_addr, 0);
        chk("stall_release_data", cur_data(), 32'h10203040);
        next_cycle();

        // abort after two bytes of group 3
        do_reset();
        pulse_start();
        for (int g = 0; g < 3; g++) begin
            feed4(8'(g), 8'(g + 16), 8'(g + 32), 8'(g + 48));
            next_cycle();
        end
        in_valid = 1'b1; in_data = 8'h91; next_cycle();
        in_valid = 1'b1; in_data = 8'h92; next_cycle();
        in_valid = 1'b0; abort = 1'b1;
        @(negedge clk);
        chk("abort_cycle_wr_en", wr_en, 0);
        next_cycle();
        abort = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort_busy", busy, 0);
            chk("abort_wr_en", wr_en, 0);
            chk("abort_done", done, 0);
            next_cycle();
        end
        pulse_start();
        feed4(8'hE1, 8'hE2, 8'hE3, 8'hE4);
        @(negedge clk);
        chk("restart_wr_en", wr_en, 1);
        chk("restart_addr", wr_addr, 0);
        chk("restart_data", cur_data(), 32'hE1E2E3E4);
        next_cycle();

        // reset in the middle of a run at address 100
        do_reset();
        pulse_start();
        for (int g = 0; g < 100; g++) begin
            feed4(8'(g), 8'(g + 1), 8'(g + 2), 8'(g + 3));
            if (g == 99) begin
                @(negedge clk);
                chk("midrun_addr99", wr_addr, 99);
            end
            next_cycle();
        end
        in_valid = 1'b1; in_data = 8'h5A; next_cycle();
        in_data = 8'h77;
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_wr_en", wr_en, 0);
        chk("midrst_wr_addr", wr_addr, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_wr_data", cur_data(), 0);
        next_cycle();
        wen_seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (wr_en) wen_seen++;
            next_cycle();
        end
        chk("midrst_no_write", wen_seen, 0);
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
